// File: rtl/midi_pkg.sv
// midi_pkg: shared MIDI status nibbles, encoder FSM states and byte type
package midi_pkg;
  localparam logic [3:0] MIDI_NOTE_ON = 4'h9;
  localparam logic [3:0] MIDI_NOTE_OFF = 4'h8;
  typedef enum logic [1:0] {IDLE, STATUS, DATA1, DATA2} state_t;
  typedef logic [7:0] midi_byte_t;
endpackage

// File: rtl/uart_tx.sv
// uart_tx: 8N1 LSB-first serial transmitter with back-to-back byte handoff
// Ports: clk, reset (async, active-low), byte_valid/byte_ready/data byte
// handshake, tx serial line (idles high), idle (no frame in progress).
// tx is registered one clock behind the bit state, so a byte accepted from
// idle starts its start bit one clock after acceptance.
module uart_tx
  import midi_pkg::*;
#(
  parameter int F_CLK = 12_000_000,
  parameter int BAUD = 31_250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       byte_valid,
  output logic       byte_ready,
  input  logic [7:0] data,
  output logic       tx,
  output logic       idle
);
  localparam int BIT_CYCLES = F_CLK / BAUD;
  localparam int CW = $clog2(BIT_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic [3:0] idx;
  logic active, last_cnt, line;
  midi_byte_t sh;
  assign last_cnt = cnt == CW'(BIT_CYCLES - 1);
  assign idle = !active;
  // Ready in the final stop-bit clock so the next start bit follows with no gap.
  assign byte_ready = !active || (idx == 4'd9 && last_cnt);
  assign line = idx == 4'd0 ? 1'b0 : idx == 4'd9 ? 1'b1 : sh[3'(idx - 4'd1)];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      active <= 1'b0;
      idx <= '0;
      cnt <= '0;
      sh <= '0;
      tx <= 1'b1;
    end else begin
      tx <= active ? line : 1'b1;
      if (byte_valid && byte_ready) begin
        active <= 1'b1;
        idx <= '0;
        cnt <= '0;
        sh <= data;
      end else if (active) begin
        cnt <= last_cnt ? '0 : cnt + 1'b1;
        if (last_cnt) begin
          idx <= idx + 4'd1;
          if (idx == 4'd9) active <= 1'b0;
        end
      end
    end
endmodule

// File: rtl/midi_event_tx.sv
// midi_event_tx: turns detector note changes into MIDI Note On/Off on a UART line
// Ports: clk, reset (async, active-low), midi[6:0] + note_on from the
// detector, tx MIDI OUT line (idles high), busy (message in progress).
// Option MIDI_RUNNING_STATUS_EN: Note Off sent as 0x9n/vel 0 and the
// status byte is omitted when it repeats the last one sent.
module midi_event_tx
  import midi_pkg::*;
#(
  parameter int F_CLK = 12_000_000,
  parameter int BAUD = 31_250,
  parameter int CHANNEL = 0,
  parameter int VELOCITY = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] midi,
  input  logic       note_on,
  output logic       tx,
  output logic       busy
);
  localparam midi_byte_t ON_ST = {MIDI_NOTE_ON, 4'(CHANNEL)};
`ifdef MIDI_RUNNING_STATUS_EN
  localparam midi_byte_t OFF_ST = ON_ST;
`else
  localparam midi_byte_t OFF_ST = {MIDI_NOTE_OFF, 4'(CHANNEL)};
`endif
  state_t st, st_n;
  logic cur_on, off_ev, on_ev, skip, byte_valid, byte_ready, uart_idle;
  logic [6:0] cur_note;
  midi_byte_t b_st, b_d1, b_d2, data, ev_st;
  assign off_ev = cur_on && (!note_on || midi != cur_note);
  assign on_ev = !cur_on && note_on;
  assign ev_st = off_ev ? OFF_ST : ON_ST;
`ifdef MIDI_RUNNING_STATUS_EN
  midi_byte_t last_status;
  assign skip = ev_st == last_status;
  always_ff @(posedge clk or negedge reset)
    if (!reset) last_status <= 8'h00;
    else if (st == STATUS && byte_ready) last_status <= b_st;
`else
  assign skip = 1'b0;
`endif
  // The FSM is only non-idle ahead of the UART for the single accept cycle,
  // so the UART alone sets busy and keeps it aligned with the serial frame.
  assign busy = !uart_idle;
  always_comb begin
    st_n = st;
    byte_valid = st != IDLE;
    data = st == STATUS ? b_st : st == DATA1 ? b_d1 : b_d2;
    if (st == IDLE) st_n = off_ev || on_ev ? (skip ? DATA1 : STATUS) : IDLE;
    else if (byte_ready) st_n = st == STATUS ? DATA1 : st == DATA1 ? DATA2 : IDLE;
  end
  // Message bytes are captured on leaving IDLE so later input changes cannot
  // corrupt a message in flight.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st <= IDLE;
      cur_on <= 1'b0;
      cur_note <= '0;
      b_st <= '0;
      b_d1 <= '0;
      b_d2 <= '0;
    end else begin
      st <= st_n;
      if (st == IDLE && off_ev) begin
        b_st <= ev_st;
        b_d1 <= {1'b0, cur_note};
        b_d2 <= '0;
        cur_on <= 1'b0;
      end else if (st == IDLE && on_ev) begin
        b_st <= ev_st;
        b_d1 <= {1'b0, midi};
        b_d2 <= {1'b0, 7'(VELOCITY)};
        cur_note <= midi;
        cur_on <= 1'b1;
      end
    end
  uart_tx #(.F_CLK(F_CLK), .BAUD(BAUD)) u_uart (
    .clk(clk),
    .reset(reset),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .data(data),
    .tx(tx),
    .idle(uart_idle)
  );
endmodule

// File: tb/tb_midi_event_tx.sv
// tb_midi_event_tx: scoreboard bench decoding MIDI OUT frames against queued bytes
module tb_midi_event_tx;
  localparam int F_CLK = 1_200_000;
  localparam int BAUD = 31_250;
  localparam int BC = F_CLK / BAUD;
`ifdef MIDI_RUNNING_STATUS_EN
  localparam logic [7:0] OFF_S = 8'h90;
`else
  localparam logic [7:0] OFF_S = 8'h80;
`endif
  logic clk = 0, reset = 0, note_on = 0, tx, busy;
  logic [6:0] midi = 0;
  int vectors = 0, miscompares = 0, cyc = 0, exp_bytes = 0;
  logic [7:0] q[$];
  logic [7:0] m_last = 8'h00;
  midi_event_tx #(.F_CLK(F_CLK), .BAUD(BAUD), .CHANNEL(0), .VELOCITY(100)) dut (
    .clk(clk),
    .reset(reset),
    .midi(midi),
    .note_on(note_on),
    .tx(tx),
    .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask
  task automatic push_msg(input logic [7:0] s, input logic [7:0] d1, input logic [7:0] d2);
`ifdef MIDI_RUNNING_STATUS_EN
    if (s != m_last) begin
      q.push_back(s);
      exp_bytes++;
    end
    m_last = s;
`else
    q.push_back(s);
    exp_bytes++;
`endif
    q.push_back(d1);
    q.push_back(d2);
    exp_bytes += 2;
  endtask
  task automatic wait_busy(input logic lvl, input int lim, output int t);
    int n = 0;
    while (busy !== lvl && n < lim) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy !== lvl) chk("busy_wait_timeout", int'(busy), int'(lvl));
    t = cyc;
  endtask
  task automatic run_msg(input string name, input int slack);
    int t0, t1, d, e;
    wait_busy(1'b1, 50, t0);
    wait_busy(1'b0, 80 * 10 * BC, t1);
    d = t1 - t0;
    e = exp_bytes * 10 * BC;
    chk(name, (d >= e && d <= e + slack) ? e : d, e);
  endtask
  initial begin
    logic [7:0] b;
    logic stop;
    bit ok;
    forever begin
      @(negedge clk);
      if (reset && !tx) begin
        ok = 1;
        repeat (BC / 2) @(negedge clk);
        ok &= reset && !tx;
        for (int i = 0; i < 8; i++) begin
          repeat (BC) @(negedge clk);
          b[i] = tx;
          ok &= reset;
        end
        repeat (BC) @(negedge clk);
        stop = tx;
        ok &= reset;
        if (ok) begin
          if (q.size() == 0) chk("spurious_byte", int'(b), -1);
          else begin
            chk("byte", int'(b), int'(q.pop_front()));
            chk("stop_bit", int'(stop), 1);
          end
        end
      end
    end
  end
  initial begin
    #(10 * 200_000);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int bad, t0, t1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx", int'(tx), 1);
    chk("reset_busy", int'(busy), 0);
    @(negedge clk) reset = 1;
    bad = 0;
    repeat (2000) begin
      @(posedge clk);
      #1;
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("idle_2000", bad, 0);
    exp_bytes = 0;
    push_msg(8'h90, 8'h45, 8'h64);
    note_on = 1;
    midi = 69;
    @(posedge clk);
    #1;
    chk("lat_n_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    chk("lat_n1_busy", int'(busy), 1);
    chk("lat_n1_tx", int'(tx), 1);
    t0 = cyc;
    @(posedge clk);
    #1;
    chk("lat_n2_tx", int'(tx), 0);
    wait_busy(1'b0, 40 * 10 * BC, t1);
    chk("on_busy_len", t1 - t0, 30 * BC);
    exp_bytes = 0;
    push_msg(OFF_S, 8'h45, 8'h00);
    note_on = 0;
    run_msg("off_busy_len", 0);
    exp_bytes = 0;
    push_msg(8'h90, 8'h45, 8'h64);
    note_on = 1;
    run_msg("reon_busy_len", 0);
    exp_bytes = 0;
    push_msg(OFF_S, 8'h45, 8'h00);
    push_msg(8'h90, 8'h4C, 8'h64);
    midi = 76;
    run_msg("change_busy_len", 2);
    exp_bytes = 0;
    push_msg(OFF_S, 8'h4C, 8'h00);
    note_on = 0;
    midi = 69;
    run_msg("off76_busy_len", 0);
    exp_bytes = 0;
    push_msg(8'h90, 8'h45, 8'h64);
    note_on = 1;
    wait_busy(1'b1, 50, t0);
    repeat (200) @(posedge clk);
    #1;
    note_on = 0;
    repeat (50) @(posedge clk);
    #1;
    note_on = 1;
    wait_busy(1'b0, 40 * 10 * BC, t1);
    chk("pulse_busy_len", t1 - t0, exp_bytes * 10 * BC);
    bad = 0;
    repeat (20 * BC) begin
      @(posedge clk);
      #1;
      if (busy !== 1'b0 || tx !== 1'b1) bad++;
    end
    chk("pulse_no_extra", bad, 0);
    note_on = 0;
    wait_busy(1'b1, 50, t0);
    repeat (5 * BC) @(posedge clk);
    #3;
    chk("pre_reset_tx", int'(tx), 0);
    reset = 0;
    m_last = 8'h00;
    #1;
    chk("mid_reset_tx", int'(tx), 1);
    chk("mid_reset_busy", int'(busy), 0);
    repeat (2 * BC) @(posedge clk);
    @(negedge clk) reset = 1;
    repeat (12 * BC) @(posedge clk);
    #1;
    chk("post_reset_busy", int'(busy), 0);
    exp_bytes = 0;
    push_msg(8'h90, 8'h45, 8'h64);
    note_on = 1;
    midi = 69;
    run_msg("post_reset_len", 0);
    repeat (100) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
